// File: rtl/mdrp_responder.sv
// -----------------------------------------------------------------------------
// mdrp_responder
//   Target end of the PLL dynamic-reconfiguration port (MDRP). Holds a bank of
//   DEPTH 8-bit registers reached through an auto-incrementing address pointer,
//   and models PLL lock: lock drops on every effective configuration write and
//   re-asserts LOCK_DELAY cycles after the last such write (or reset release).
//   Register 0 is a read-only ID register.
//
// Ports
//   mdclk      in   1      sole clock, rising edge
//   reset      in   1      synchronous, active-high reset
//   mdopc      in   2      00 NOP, 01 WRITE, 10 READ, 11 ADDR_LOAD
//   mdainc     in   1      post-increment pointer after WRITE/READ
//   mdwdi      in   8      write data (WRITE) or address (ADDR_LOAD)
//   mdrdo      out  8      registered read data, held until next READ
//   lock       out  1      modelled PLL lock
//   cfg_addr   in   AW     side-port read address
//   cfg_data   out  8      registered side-port read data
//   wr_strobe  out  1      one-cycle pulse per effective write
// -----------------------------------------------------------------------------
module mdrp_responder #(
    parameter int         DEPTH      = 64,
    parameter int         LOCK_DELAY = 64,
    parameter logic [7:0] ID_VALUE   = 8'hA5
) (
    input  logic                     mdclk,
    input  logic                     reset,
    input  logic [1:0]               mdopc,
    input  logic                     mdainc,
    input  logic [7:0]               mdwdi,
    output logic [7:0]               mdrdo,
    output logic                     lock,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    output logic [7:0]               cfg_data,
    output logic                     wr_strobe
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LOCK_DELAY) + 1;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    localparam logic [0:0] ST_RELOCK = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_DELAY - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    logic [7:0]    regs_r [DEPTH];
    logic [AW-1:0] addr_r;
    logic [AW-1:0] addr_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [0:0]    state_r;
    logic [0:0]    state_s;
    logic          eff_write_s;

    // Effective write: a WRITE that does not target the read-only ID register.
    always_comb begin
        eff_write_s = 1'b0;
        if ((mdopc == OP_WRITE) && (addr_r != {AW{1'b0}})) begin
            eff_write_s = 1'b1;
        end else begin
            eff_write_s = 1'b0;
        end
    end

    // Next address pointer; increment wraps naturally in AW bits.
    always_comb begin
        addr_s = addr_r;
        case (mdopc)
            OP_WRITE, OP_READ: begin
                if (mdainc) begin
                    addr_s = addr_r + AW'(1'b1);
                end else begin
                    addr_s = addr_r;
                end
            end
            OP_LOAD: addr_s = mdwdi[AW-1:0];
            OP_NOP:  addr_s = addr_r;
            default: addr_s = addr_r;
        endcase
    end

    // Lock FSM next state; a write always wins over the terminal count.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_RELOCK: begin
                if (eff_write_s) begin
                    state_s = ST_RELOCK;
                    cnt_s   = {CW{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_LOCKED;
                    cnt_s   = cnt_r;
                end else begin
                    state_s = ST_RELOCK;
                    if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + CW'(1'b1);
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
            end
            ST_LOCKED: begin
                if (eff_write_s) begin
                    state_s = ST_RELOCK;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = ST_LOCKED;
                    cnt_s   = cnt_r;
                end
            end
            default: begin
                state_s = ST_RELOCK;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge mdclk) begin
        if (reset) begin
            addr_r    <= {AW{1'b0}};
            mdrdo     <= 8'h00;
            cfg_data  <= 8'h00;
            wr_strobe <= 1'b0;
            lock      <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            state_r   <= ST_RELOCK;
        end else begin
            addr_r <= addr_s;
            if (mdopc == OP_READ) begin
                mdrdo <= regs_r[addr_r];
            end
            cfg_data  <= regs_r[cfg_addr];
            wr_strobe <= eff_write_s;
            cnt_r     <= cnt_s;
            state_r   <= state_s;
            lock      <= (state_s == ST_LOCKED);
        end
    end

    // Register bank; entry 0 only ever takes the ID value.
    always_ff @(posedge mdclk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= (i == 0) ? ID_VALUE : 8'h00;
            end
        end else if (eff_write_s) begin
            regs_r[addr_r] <= mdwdi;
        end
    end

endmodule
